// File: rtl/simplez_pkg.sv
// Shared definitions for the simplez serial blocks.
//   PARITY_*          parity mode selector values
//   ST_*              framing FSM state encoding (3 bits)
//   BAUD_DIV_DEFAULT  clk cycles per bit for 12 MHz / 115200 baud
//   calc_parity()     parity bit for a data word under a given mode
package simplez_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam int BAUD_DIV_DEFAULT = 104;

  // Callers zero-extend narrower words; the extra zeros leave the XOR untouched.
  function automatic logic calc_parity(input logic [15:0] data, input int parity);
    return (^data) ^ (parity == PARITY_ODD);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst       clock, asynchronous active-high reset
//   push, din      write request and data; ignored while full
//   pop, dout      read request; dout always shows the head entry
//   level          occupancy 0..DEPTH (registered)
//   full, empty    decoded from level
module fifo_sync #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          push_ok, pop_ok;

  // full is the registered view, so a pop on the same edge does not make room.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign full  = (level_q == (AW + 1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; only pointers and level define
  // which entries are valid, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered serial transmitter: FIFO in front of a start/data/parity/stop framer.
//   clk, rst        clock, asynchronous active-high reset
//   wr_en, din      push one word per cycle (dropped while full)
//   full, empty     FIFO status; level = occupancy 0..DEPTH
//   busy            a frame is on the line
//   ovf, ovf_clr    sticky dropped-push flag and its clear
//   tx              serial output, idle high, LSB first
module uart_tx_fifo
  import simplez_pkg::*;
#(
  parameter int DW        = 8,
  parameter int BAUD_DIV  = BAUD_DIV_DEFAULT,
  parameter int DEPTH     = 16,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DW-1:0]            din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic                     tx
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = 1;
  localparam logic [3:0]    DATA_LAST = 4'(DW - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [DW-1:0] shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, ovf_q, ovf_d;
  logic          fifo_pop;
  logic [DW-1:0] fifo_dout;
  logic          baud_end;

  fifo_sync #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (din),
    .dout  (fifo_dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign baud_end = (baud_q == BAUD_LAST);
  // Dropping a push wins over a same-edge clear.
  assign ovf_d    = (wr_en & full) | (ovf_q & ~ovf_clr);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BAUD_ONE;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = 1'b1;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          par_d    = calc_parity(16'(fifo_dout), PARITY);
          state_d  = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PAR: begin
        tx_d = par_q;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next start bit when more data waits.
            if (!empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_dout;
              par_d    = calc_parity(16'(fifo_dout), PARITY);
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // tx and busy are registered from the current state, so the line is
  // glitch-free and trails the state register by exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != ST_IDLE);
      ovf_q   <= ovf_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int BD    = 4;
  localparam int NI    = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] din = 8'h00;

  always #5 clk = ~clk;

  logic       o_tx[NI], o_busy[NI], o_full[NI], o_empty[NI], o_ovf[NI];
  logic [4:0] o_level[NI];

  // u0: 8N1, u1: 8E1, u2: 8O1, u3: 7N2 -- all fed the same stimulus.
  uart_tx_fifo #(.DW(8), .BAUD_DIV(BD), .DEPTH(DEPTH), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(o_full[0]), .empty(o_empty[0]),
    .level(o_level[0]), .busy(o_busy[0]), .ovf(o_ovf[0]), .ovf_clr(ovf_clr), .tx(o_tx[0]));
  uart_tx_fifo #(.DW(8), .BAUD_DIV(BD), .DEPTH(DEPTH), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(o_full[1]), .empty(o_empty[1]),
    .level(o_level[1]), .busy(o_busy[1]), .ovf(o_ovf[1]), .ovf_clr(ovf_clr), .tx(o_tx[1]));
  uart_tx_fifo #(.DW(8), .BAUD_DIV(BD), .DEPTH(DEPTH), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(o_full[2]), .empty(o_empty[2]),
    .level(o_level[2]), .busy(o_busy[2]), .ovf(o_ovf[2]), .ovf_clr(ovf_clr), .tx(o_tx[2]));
  uart_tx_fifo #(.DW(7), .BAUD_DIV(BD), .DEPTH(DEPTH), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din[6:0]), .full(o_full[3]), .empty(o_empty[3]),
    .level(o_level[3]), .busy(o_busy[3]), .ovf(o_ovf[3]), .ovf_clr(ovf_clr), .tx(o_tx[3]));

  function automatic int cfg_dw(int i);  return (i == 3) ? 7 : 8; endfunction
  function automatic int cfg_par(int i); return (i == 1) ? 1 : (i == 2) ? 2 : 0; endfunction
  function automatic int cfg_sb(int i);  return (i == 3) ? 2 : 1; endfunction
  function automatic int frame_len(int i);
    return (1 + cfg_dw(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_sb(i)) * BD;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus the current frame as a list of line
  // bits. rem counts the cycles left in the frame on the framer's timeline;
  // the pin shows each cycle's bit one clock later.
  int         mq[NI][$];
  int         rem[NI];
  int         fl[NI];
  logic [15:0] fb[NI];
  logic       m_tx[NI], m_busy[NI], m_ovf[NI];
  int         busy_cnt[NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      rem[i]  = 0;
      fl[i]   = 0;
      fb[i]   = '0;
      m_tx[i] = 1'b1;
      m_busy[i] = 1'b0;
      m_ovf[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      logic cur_tx, was_full, was_empty;
      int   w, idx;
      cur_tx    = (rem[i] > 0) ? fb[i][(fl[i] - rem[i]) / BD] : 1'b1;
      m_busy[i] = (rem[i] > 0);
      was_full  = (mq[i].size() == DEPTH);
      was_empty = (mq[i].size() == 0);
      if (rem[i] <= 1 && !was_empty) begin
        w = mq[i].pop_front();
        fb[i] = '0;
        idx = 1;                              // bit 0 is the start bit (0)
        for (int k = 0; k < cfg_dw(i); k++) begin
          fb[i][idx] = w[k];
          idx++;
        end
        if (cfg_par(i) != 0) begin
          fb[i][idx] = ($countones(w) % 2 == 1) ^ (cfg_par(i) == 2);
          idx++;
        end
        for (int s = 0; s < cfg_sb(i); s++) begin
          fb[i][idx] = 1'b1;
          idx++;
        end
        fl[i]  = idx * BD;
        rem[i] = fl[i];
      end else if (rem[i] > 0) begin
        rem[i]--;
      end
      if (wr_en && !was_full) mq[i].push_back(int'(din) & ((1 << cfg_dw(i)) - 1));
      m_ovf[i] = (wr_en && was_full) || (m_ovf[i] && !ovf_clr);
      m_tx[i]  = cur_tx;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.tx", i),    o_tx[i],    m_tx[i]);
      check($sformatf("u%0d.busy", i),  o_busy[i],  m_busy[i]);
      check($sformatf("u%0d.level", i), o_level[i], mq[i].size());
      check($sformatf("u%0d.empty", i), o_empty[i], mq[i].size() == 0);
      check($sformatf("u%0d.full", i),  o_full[i],  mq[i].size() == DEPTH);
      check($sformatf("u%0d.ovf", i),   o_ovf[i],   m_ovf[i]);
      if (o_busy[i]) busy_cnt[i]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [7:0] w);
    wr_en = 1'b1;
    din   = w;
    step();
    wr_en = 1'b0;
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NI; i++) if (o_busy[i] || !o_empty[i]) return 1'b0;
    return 1'b1;
  endfunction

  // busy trails the pop by a cycle, so require several quiet samples.
  task automatic drain(input int max_cycles);
    int c = 0;
    int quiet = 0;
    while (quiet < 3 && c < max_cycles) begin
      step();
      c++;
      quiet = all_idle() ? quiet + 1 : 0;
    end
    check("drain_done", all_idle(), 1'b1);
  endtask

  task automatic clear_busy_cnt();
    for (int i = 0; i < NI; i++) busy_cnt[i] = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Single 0x55 frame on each configuration.
    clear_busy_cnt();
    push(8'h55);
    drain(200);
    for (int i = 0; i < NI; i++) check($sformatf("u%0d.frame_busy", i), busy_cnt[i], frame_len(i));

    // Back-to-back frames without an idle gap.
    clear_busy_cnt();
    push(8'hA0);
    push(8'h0F);
    drain(300);
    for (int i = 0; i < NI; i++) check($sformatf("u%0d.b2b_busy", i), busy_cnt[i], 2 * frame_len(i));

    // 7-bit, two-stop-bit frame.
    clear_busy_cnt();
    push(8'h7F);
    drain(200);
    check("u3.stop2_busy", busy_cnt[3], 40);

    // Overflow: 18 consecutive pushes, one popped, 16 stored, one dropped.
    for (int k = 0; k < 18; k++) begin
      wr_en = 1'b1;
      din   = 8'(k * 13 + 1);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.ovf_set", i),  o_ovf[i],   1'b1);
      check($sformatf("u%0d.ovf_full", i), o_full[i],  1'b1);
      check($sformatf("u%0d.ovf_lvl", i),  o_level[i], 16);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    for (int i = 0; i < NI; i++) check($sformatf("u%0d.ovf_clr", i), o_ovf[i], 1'b0);
    drain(1000);

    // Reset in the middle of a start bit with words queued.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    step();
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.rst_tx", i),  o_tx[i],    1'b1);
      check($sformatf("u%0d.rst_lvl", i), o_level[i], 0);
    end
    model_reset();
    step();
    rst = 1'b0;
    step();

    // Randomised traffic, including overflow and same-edge clear.
    for (int n = 0; n < 1500; n++) begin
      wr_en   = ($urandom_range(0, 9) == 0);
      din     = 8'($urandom);
      ovf_clr = ($urandom_range(0, 49) == 0);
      step();
    end
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    drain(1200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
